// File: rtl/gray_pkg.sv
// Shared mode encodings and Gray conversion helpers for the gray_codec slice.
package gray_pkg;

  localparam logic [1:0] MODE_B2G = 2'b00;
  localparam logic [1:0] MODE_G2B = 2'b01;
  localparam logic [1:0] MODE_BCD = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  // Helpers work on a zero-extended word; zero upper bits leave the low WIDTH bits exact.
  localparam int GMAX = 64;

  function automatic logic [GMAX-1:0] b2g(input logic [GMAX-1:0] d);
    return d ^ (d >> 1);
  endfunction

  function automatic logic [GMAX-1:0] g2b(input logic [GMAX-1:0] g);
    logic [GMAX-1:0] b;
    b[GMAX-1] = g[GMAX-1];
    for (int i = GMAX - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/gray_nibble.sv
// One packed-BCD digit converted to 4-bit Gray, with a flag for a legal digit (0..9).
module gray_nibble (
  input  logic [3:0] nib_i,
  output logic [3:0] gray_o,
  output logic       digit_ok_o
);

  assign gray_o     = nib_i ^ (nib_i >> 1);
  assign digit_ok_o = (nib_i <= 4'd9);

endmodule

// File: rtl/gray_codec.sv
// Registered binary/Gray/BCD code converter with valid/ready on both sides
// and a saturating count of beats flagged in error.
module gray_codec
  import gray_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ERRW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic [ERRW-1:0]  err_count,
  input  logic             clr_err
);

  localparam int NNIB = WIDTH / 4;
  localparam int REM  = WIDTH % 4;
  localparam int NB   = (NNIB > 0) ? NNIB : 1;

  logic [WIDTH-1:0] bcd_gray;
  logic [NB-1:0]    nib_ok;
  logic [GMAX-1:0]  ext;

  logic             vld_q, err_q;
  logic [WIDTH-1:0] data_q;
  logic [ERRW-1:0]  cnt_q;
  logic [WIDTH-1:0] data_d;
  logic             err_d;
  logic             accept;

  assign ext = GMAX'(in_data);

  generate
    if (NNIB > 0) begin : g_nib
      for (genvar k = 0; k < NNIB; k++) begin : g_slice
        gray_nibble u_nib (
          .nib_i      (in_data[4*k +: 4]),
          .gray_o     (bcd_gray[4*k +: 4]),
          .digit_ok_o (nib_ok[k])
        );
      end
    end else begin : g_no_nib
      assign nib_ok = '1;
    end

    // Leftover top bits are plain bin2gray and never flag an error.
    if (REM > 0) begin : g_part
      logic [REM-1:0] top;
      assign top = in_data[WIDTH-1 -: REM];
      assign bcd_gray[WIDTH-1 -: REM] = top ^ (top >> 1);
    end
  endgenerate

  always_comb begin
    data_d = WIDTH'(b2g(ext));
    err_d  = 1'b0;
    case (in_mode)
      MODE_G2B: data_d = WIDTH'(g2b(ext));
      MODE_BCD: begin
        data_d = bcd_gray;
        err_d  = ~(&nib_ok);
      end
      MODE_RSV: err_d = 1'b1;
      default:  ;
    endcase
  end

  assign in_ready = !vld_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (accept) begin
        vld_q  <= 1'b1;
        data_q <= data_d;
        err_q  <= err_d;
      end else if (out_ready) begin
        vld_q <= 1'b0;
      end
      if (clr_err)
        cnt_q <= '0;
      else if (accept && err_d && (cnt_q != '1))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = data_q;
  assign out_err   = err_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_gray_codec.sv
// Directed-vector bench for gray_codec at WIDTH=8 with hand-computed expectations.
module tb_gray_codec;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, out_err, clr_err;
  logic [1:0] in_mode;
  logic [7:0] in_data, out_data, err_count;

  int n_chk = 0;
  int n_pass = 0;

  gray_codec #(.WIDTH(8), .ERRW(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .err_count(err_count), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] bp_in  [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
  logic [7:0] bp_exp [4] = '{8'h01, 8'h03, 8'h02, 8'h06};
  logic       bp_rdy [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    int sent, recv;
    logic       held_vld;
    logic [7:0] held;

    rst = 1'b1; in_valid = 1'b1; in_mode = 2'b00; in_data = 8'hFF;
    out_ready = 1'b1; clr_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_valid", out_valid, 0);
      chk("rst_cnt", err_count, 0);
      chk("rst_data", out_data, 8'h00);
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_ready", in_ready, 1);

    // bin2gray then gray2bin back to back
    in_valid = 1'b1; in_mode = 2'b00; in_data = 8'hB4;
    step();
    chk("b2g_valid", out_valid, 1);
    chk("b2g_data", out_data, 8'hEE);
    chk("b2g_err", out_err, 0);
    in_mode = 2'b01; in_data = 8'hEE;
    step();
    chk("g2b_valid", out_valid, 1);
    chk("g2b_data", out_data, 8'hB4);
    chk("g2b_err", out_err, 0);

    in_mode = 2'b10; in_data = 8'h59;
    step();
    chk("bcd_ok_data", out_data, 8'h7D);
    chk("bcd_ok_err", out_err, 0);
    in_data = 8'h5A;
    step();
    chk("bcd_bad_data", out_data, 8'h7F);
    chk("bcd_bad_err", out_err, 1);
    in_valid = 1'b0;
    step();
    chk("bcd_cnt", err_count, 1);
    chk("drain_valid", out_valid, 0);

    // Backpressure: scoreboard of 4 beats against a toggling out_ready
    sent = 0; recv = 0; held_vld = 1'b0; held = '0;
    in_mode = 2'b00;
    for (int c = 0; c < 20 && recv < 4; c++) begin
      out_ready = (c < 6) ? bp_rdy[c] : 1'b1;
      in_valid  = (sent < 4);
      in_data   = bp_in[(sent < 4) ? sent : 3];
      #1;
      if (out_valid && out_ready) begin
        chk("bp_data", out_data, bp_exp[recv]);
        recv++;
      end
      if (out_valid && !out_ready) begin
        chk("bp_stall_ready", in_ready, 0);
        if (held_vld) chk("bp_stable", out_data, held);
        held_vld = 1'b1; held = out_data;
        in_mode = 2'b01;  // must not disturb the held beat
      end else begin
        held_vld = 1'b0;
        in_mode = 2'b00;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    chk("bp_sent", sent, 4);
    chk("bp_recv", recv, 4);
    in_valid = 1'b0; out_ready = 1'b1; in_mode = 2'b00;
    step();

    in_valid = 1'b1; in_mode = 2'b11; in_data = 8'h03;
    step();
    chk("rsv_data", out_data, 8'h02);
    chk("rsv_err", out_err, 1);
    chk("rsv_cnt", err_count, 2);
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 252) chk("sat_reach", err_count, 8'hFF);
    end
    chk("sat_hold", err_count, 8'hFF);
    clr_err = 1'b1;
    step();
    chk("clr_prio", err_count, 0);
    clr_err = 1'b0; in_valid = 1'b0;
    step();

    // Reset while a beat is stalled at the output
    in_valid = 1'b1; in_mode = 2'b00; in_data = 8'h10; out_ready = 1'b0;
    step();
    chk("mid_pre_valid", out_valid, 1);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    step();
    rst = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_mode = 2'b01; in_data = 8'h0C;
    step();
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_data", out_data, 8'h08);
    in_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
